// File: rtl/pipeline_hs.sv
// Four-stage add / select / multiply datapath with valid/ready flow control,
// bubble collapsing, synchronous flush and optional saturating add.
module pipeline_hs #(
  parameter int WIDTH   = 8,
  parameter bit SAT_ADD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     d,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     c,
  input  logic                 ctl,
  input  logic [WIDTH-1:0]     e,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic [2:0]           occupancy
);

  logic v1_q, v2_q, v3_q, v4_q;
  logic v1_d, v2_d, v3_d, v4_d;
  logic [2:0] occ_q, occ_d;

  logic [WIDTH-1:0]   s1_dat_q, s1_a_q, s1_c_q, s1_e_q;
  logic               s1_ctl_q;
  logic [WIDTH-1:0]   s2_sum_q, s2_c_q, s2_e_q;
  logic               s2_ctl_q;
  logic [WIDTH-1:0]   s3_sel_q, s3_e_q;
  logic [2*WIDTH-1:0] s4_prod_q;

  logic rdy1, rdy2, rdy3, rdy4;
  logic accept;
  logic [WIDTH:0]     sum_full;
  logic [WIDTH-1:0]   sum_w;
  logic [WIDTH-1:0]   sel_w;
  logic [2*WIDTH-1:0] prod_w;

  assign rdy4 = !v4_q || out_ready;
  assign rdy3 = !v3_q || rdy4;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;

  // Reset is folded in so the producer sees no acceptance while held in reset.
  assign in_ready = reset && rdy1 && !flush;
  assign accept   = in_valid && in_ready;

  assign sum_full = {1'b0, s1_dat_q} + {1'b0, s1_a_q};
  assign sum_w    = (SAT_ADD && sum_full[WIDTH]) ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
  assign sel_w    = s2_ctl_q ? s2_c_q : s2_sum_q;
  assign prod_w   = {{WIDTH{1'b0}}, s3_e_q} * {{WIDTH{1'b0}}, s3_sel_q};

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    v4_d = v4_q;
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
      v4_d = 1'b0;
    end else begin
      if (rdy1) v1_d = accept;
      if (rdy2) v2_d = v1_q;
      if (rdy3) v3_d = v2_q;
      if (rdy4) v4_d = v3_q;
    end
    occ_d = {2'b00, v1_d} + {2'b00, v2_d} + {2'b00, v3_d} + {2'b00, v4_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      v4_q      <= 1'b0;
      occ_q     <= 3'd0;
      s1_dat_q  <= '0;
      s1_a_q    <= '0;
      s1_c_q    <= '0;
      s1_ctl_q  <= 1'b0;
      s1_e_q    <= '0;
      s2_sum_q  <= '0;
      s2_c_q    <= '0;
      s2_ctl_q  <= 1'b0;
      s2_e_q    <= '0;
      s3_sel_q  <= '0;
      s3_e_q    <= '0;
      s4_prod_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      v4_q  <= v4_d;
      occ_q <= occ_d;
      // Data only moves with a real token; flush leaves it untouched.
      if (!flush) begin
        if (accept) begin
          s1_dat_q <= d;
          s1_a_q   <= a;
          s1_c_q   <= c;
          s1_ctl_q <= ctl;
          s1_e_q   <= e;
        end
        if (rdy2 && v1_q) begin
          s2_sum_q <= sum_w;
          s2_c_q   <= s1_c_q;
          s2_ctl_q <= s1_ctl_q;
          s2_e_q   <= s1_e_q;
        end
        if (rdy3 && v2_q) begin
          s3_sel_q <= sel_w;
          s3_e_q   <= s2_e_q;
        end
        if (rdy4 && v3_q) begin
          s4_prod_q <= prod_w;
        end
      end
    end
  end

  assign out_valid = v4_q;
  assign out_data  = s4_prod_q;
  assign occupancy = occ_q;

endmodule

// File: doc/pipeline_hs.md
Name: pipeline_hs

Overview:
- Parametrised successor to the team's 4-stage add/select/multiply datapath pipeline.
- Adds valid/ready flow control with per-stage bubble collapsing, a synchronous flush, and optional saturating add.
- Side operands (a, c, ctl, e) are captured with each input token and travel with it through the stages, so mid-stream operand changes affect only later tokens.
- Sits between a producing datapath block and a consumer that may stall.

Parameters:
- WIDTH, 8, bit width of the data path and all operands; product is 2*WIDTH.
- SAT_ADD, 0, 0 = stage-2 add wraps modulo 2^WIDTH; 1 = add saturates to 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all in-flight tokens.
- in_valid  input  1  input token present.
- in_ready  output  1  pipeline accepts the token this cycle.
- d  input  WIDTH  primary data.
- a  input  WIDTH  stage-2 addend.
- c  input  WIDTH  stage-3 substitute value.
- ctl  input  1  1 = stage 3 selects c; 0 = stage 3 selects the sum.
- e  input  WIDTH  stage-4 multiplier.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  2*WIDTH  result.
- occupancy  output  3  number of valid stages (0..4).

Behaviour:
- Reset (asynchronous, reset=0):
  - All stage valid bits clear.
  - All data and side-operand registers clear, so out_data=0, out_valid=0, occupancy=0.
  - in_ready=0 while reset is asserted.
  - Reset mid-operation drops every token; there is no partial output.
- Stages (a token is accepted when in_valid && in_ready):
  - S1 captures d, a, c, ctl, e.
  - S2 computes sum = d + a, WIDTH bits (wrap or saturate per SAT_ADD), and forwards c, ctl, e.
  - S3 computes sel = ctl ? c : sum, and forwards e.
  - S4 computes out_data = e * sel, unsigned, full 2*WIDTH bits, never truncated.
- Flow control:
  - Per stage i, ready_i = !v_i || ready_{i+1}; ready_5 = out_ready.
  - Stage i loads from stage i-1 when ready_i is high. Its valid becomes v_{i-1} (or in_valid && in_ready for S1).
  - in_ready = ready_1 && !flush. This is combinational from out_ready and the valid bits; there is no combinational path from in_valid.
  - Bubbles collapse: a token advances into any empty stage even while downstream stalls.
  - out_valid = v4. While out_valid && !out_ready, out_data and v4 hold stable (AXI-style rule).
- Latency: with no stall, a token accepted at edge N produces out_valid=1 after edge N+3 and is visible in the cycle following that edge. This is 4 register stages.
- Throughput: one token per cycle when out_ready stays high.
- Flush:
  - On the edge where flush=1, all valid bits clear and data registers are left unchanged.
  - in_ready=0 during flush, so no token is accepted that cycle.
  - A flush coinciding with out_valid && out_ready counts as a completed handshake for the consumer; the token is not re-presented.
- Occupancy:
  - Registered count of set valid bits, updated on each edge.
  - Equals 4 exactly when the pipeline is full and stalled; in_ready=0 in that state.
- Simultaneous events:
  - Accept and output on the same edge keep occupancy unchanged.
  - reset overrides flush, and flush overrides accept.
- Side operands are sampled only on acceptance. Changes to a/c/ctl/e while no token is accepted have no effect.

Test Plan (WIDTH=8 unless stated):
- Basic path: d=3, a=4, ctl=0, e=5, out_ready=1, single token -> out_valid high 4 cycles after accept, out_data=35, occupancy returns to 0.
- Select path and operand capture: token1 {d=1, a=1, ctl=1, c=9, e=10}, then token2 {d=2, a=2, ctl=0, e=3} on consecutive cycles -> out_data 90 then 12 on back-to-back cycles.
- Add overflow: d=200, a=100, ctl=0, e=2 -> SAT_ADD=0 gives out_data=88 (44*2); SAT_ADD=1 gives out_data=510. With WIDTH=16, d=a=e=0xFFFF, SAT_ADD=0 -> out_data=0xFFFD0002, with no product truncation.
- Backpressure: out_ready=0, drive 6 tokens d=1..6 (a=0, e=1) -> exactly 4 accepted, in_ready=0, occupancy=4, out_data=1 held stable. Release out_ready -> outputs 1..6 in order, no loss or duplication.
- Flush: 3 tokens in flight plus a new in_valid in the flush cycle -> no outputs emerge, the flush-cycle token is not accepted, occupancy=0 next cycle, and the next token processes normally.
- Reset mid-stream: assert reset asynchronously between edges with 4 tokens stalled -> out_valid, out_data and occupancy go to 0 immediately. After release, the first new token d=7, a=1, e=2 gives 16.
